// File: rtl/lcd_capture_pkg.sv
// Shared types for the LCD capture path: FSM states and the packed raw panel bus.
package lcd_capture_pkg;

    localparam int unsigned NIB_BITS = 4;

    typedef enum logic {
        StSyncWait = 1'b0,
        StActive   = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic                m;
        logic                dclk;
        logic                lp;
        logic                flm;
        logic [NIB_BITS-1:0] data;
    } pin_bus_t;

endpackage

// File: rtl/lcd_sync.sv
// N-stage, W-bit synchronizer; every bit sees the same depth so a bus stays aligned.
module lcd_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/lcd_capture.sv
// Receive side of the raw LCD bus: rebuilds framebuffer bytes from panel nibbles and
// writes them out in the same byte layout the driver reads.
module lcd_capture
    import lcd_capture_pkg::*;
#(
    parameter int unsigned H_RES       = 320,
    parameter int unsigned V_RES       = 240,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        data,
    input  logic              flm,
    input  logic              lp,
    input  logic              dclk,
    input  logic              m,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic              locked,
    output logic              m_last
);

    localparam int unsigned NibPerLine = H_RES / 4;
    localparam int unsigned LineBytes  = H_RES / 8;
    localparam int unsigned ColW       = $clog2(NibPerLine + 1);
    localparam int unsigned RowW       = $clog2(V_RES + 1);
    localparam int unsigned PinW       = $bits(pin_bus_t);

    localparam logic [ColW-1:0] ColFull = ColW'(NibPerLine);
    localparam logic [RowW-1:0] RowLast = RowW'(V_RES - 1);
    localparam logic [RowW-1:0] RowOver = RowW'(V_RES);

    pin_bus_t        raw;
    pin_bus_t        pins;
    logic [PinW-1:0] pins_flat;

    cap_state_e      state_q;
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    logic [3:0]      staged_q;
    logic            dclk_prev_q;
    logic            lp_prev_q;

    logic            dclk_fall;
    logic            lp_fall;
    logic            nib_in_range;
    logic [ColW-1:0] col_inc;
    logic [ColW-1:0] col_end;

    always_comb begin
        raw      = '0;
        raw.m    = m;
        raw.dclk = dclk;
        raw.lp   = lp;
        raw.flm  = flm;
        raw.data = data;
    end

    lcd_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PinW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw),
        .q     (pins_flat)
    );

    assign pins = pin_bus_t'(pins_flat);

    always_comb begin
        dclk_fall    = dclk_prev_q & ~pins.dclk;
        lp_fall      = lp_prev_q & ~pins.lp;
        nib_in_range = (col_q < ColFull);
        col_inc      = nib_in_range ? col_q + 1'b1 : col_q;
        // Column count as seen by a coincident line close: nibble is consumed first.
        col_end      = dclk_fall ? col_inc : col_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSyncWait;
            col_q       <= '0;
            row_q       <= '0;
            staged_q    <= '0;
            dclk_prev_q <= 1'b0;
            lp_prev_q   <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            m_last      <= 1'b0;
        end else begin
            dclk_prev_q <= pins.dclk;
            lp_prev_q   <= pins.lp;
            fb_we       <= 1'b0;
            frame_done  <= 1'b0;

            unique case (state_q)
                StSyncWait: begin
                    if (lp_fall && pins.flm) begin
                        state_q <= StActive;
                        locked  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                        m_last  <= pins.m;
                    end
                end

                StActive: begin
                    if (dclk_fall) begin
                        if (nib_in_range) begin
                            if (!col_q[0]) begin
                                staged_q <= pins.data;
                            end else if (row_q != RowOver) begin
                                fb_we    <= 1'b1;
                                fb_addr  <= ADDR_W'(row_q) * ADDR_W'(LineBytes)
                                            + ADDR_W'(col_q >> 1);
                                fb_wdata <= {staged_q, pins.data};
                            end
                        end else begin
                            line_err <= 1'b1;
                        end
                        col_q <= col_inc;
                    end

                    if (lp_fall) begin
                        if (col_end != ColFull) begin
                            line_err <= 1'b1;
                        end
                        col_q <= '0;
                        if (pins.flm) begin
                            if (row_q != RowOver) begin
                                frame_err <= 1'b1;
                            end
                            row_q  <= '0;
                            m_last <= pins.m;
                        end else if (row_q < RowLast) begin
                            row_q <= row_q + 1'b1;
                        end else if (row_q == RowLast) begin
                            frame_done <= 1'b1;
                            row_q      <= RowOver;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                default: state_q <= StSyncWait;
            endcase
        end
    end

endmodule
